instr_mem_responder: RTL

//  Instruction-memory side of the fetch interface: accepts one fetch request (byte address),

---
 rtl/instr_mem_pkg.sv | 13 +
 rtl/instr_mem_array.sv | 33 +++
 rtl/instr_mem_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] ERR_INSTR  = 32'h0000_0000;
    localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/instr_mem_array.sv
// Program storage: DEPTH x 32 words, synchronous write, combinational word-indexed read.
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    logic [31:0] mem [DEPTH];

    logic wr_in_range;
    logic rd_in_range;

    assign wr_in_range = int'(wr_addr) < DEPTH;
    assign rd_in_range = int'(rd_addr) < DEPTH;

    // Contents survive reset on purpose: a loaded program must outlive a core reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = rd_in_range ? mem[rd_addr] : ERR_INSTR;

endmodule

// File: rtl/instr_mem_responder.sv
// Fetch-side responder: one outstanding request, fixed latency, response held until acked.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_ready,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    output logic              instr_err,
    input  logic              instr_ack,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data
);

    localparam int         OFS    = $clog2(WORD_BYTES);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;

    logic [31:0]       rd_byte_addr;
    logic [ADDR_W-1:0] rd_word;
    logic              rd_ok;
    logic [31:0]       rd_data;
    logic [31:0]       resp_data;
    logic              resp_err;

    // Single-cycle latency has no BUSY edge to latch into, so it reads the live address.
    assign rd_byte_addr = (LATENCY == 1) ? fetch_addr : addr_q;
    assign rd_word      = rd_byte_addr[ADDR_W+OFS-1:OFS];
    assign rd_ok        = (rd_byte_addr[OFS-1:0] == '0)
                       && (rd_byte_addr[31:ADDR_W+OFS] == '0)
                       && (int'(rd_word) < DEPTH);

    assign resp_data = rd_ok ? rd_data : ERR_INSTR;
    assign resp_err  = !rd_ok;

    instr_mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (load_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (rd_word),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (fetch_en) begin
                    addr_d = fetch_addr;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        instr_d = resp_data;
                        err_d   = resp_err;
                    end else begin
                        state_d = BUSY;
                        count_d = LAT_M1;
                    end
                end
            end
            BUSY: begin
                count_d = count_q - 4'd1;
                // Memory is sampled on the edge that enters RESP, so earlier loads are seen.
                if (count_q == 4'd1) begin
                    state_d = RESP;
                    instr_d = resp_data;
                    err_d   = resp_err;
                end
            end
            RESP: begin
                if (instr_ack) begin
                    state_d = IDLE;
                    instr_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                instr_d = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    assign fetch_ready = (state_q == IDLE);
    assign instr_valid = (state_q == RESP);
    assign instr_out   = instr_q;
    assign instr_err   = err_q;

endmodule
